control_execute: RTL and testbench

- Control FSM for the execute stage, directly downstream of the decode-stage controller.
- Consumes the decode controller's Dec/Exe buffer-write strobe, sequences single- and multi-cycle ALU operations, and writes the Exe/Mem pipeline buffer.
- When execute cannot accept the next instruction, it drives stall request/release strobes back to the decode controller.

---
 rtl/control_execute_pkg.sv | 19 +
 rtl/control_execute_if.sv | 29 ++
 rtl/control_execute.sv | 106 ++++++++++
 tb/tb_control_execute.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/control_execute_pkg.sv
// Shared definitions for the execute-stage controller and its decode-side peer.
package control_execute_pkg;

    localparam int CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        EXE0 = 2'b00,
        EXE1 = 2'b01,
        EXE2 = 2'b10,
        EXE3 = 2'b11
    } exeState_t;

    // Stall strobe pair as seen by the decode controller.
    typedef struct packed {
        logic setStallDec;
        logic clrStallDec;
    } stallStrobe_t;

endpackage

// File: rtl/control_execute_if.sv
// Dec/Exe handshake, Exe/Mem write and stall strobes between decode and execute control.
interface control_execute_if #(parameter int CNT_W = control_execute_pkg::CNT_W_DEF);

    logic             DecExeBufferWr;
    logic             IsMultiCycle;
    logic [CNT_W-1:0] OpCycles;
    logic             MemReady;
    logic             AluEn;
    logic             MulEn;
    logic             ExeMemBufferWr;
    logic             SetStallDec;
    logic             ClrStallDec;
    logic             IsExeBusy;
    logic [CNT_W-1:0] CycleCnt;
    logic             OverrunErr;

    modport master (
        output DecExeBufferWr, IsMultiCycle, OpCycles, MemReady,
        input  AluEn, MulEn, ExeMemBufferWr, SetStallDec, ClrStallDec,
               IsExeBusy, CycleCnt, OverrunErr
    );

    modport slave (
        input  DecExeBufferWr, IsMultiCycle, OpCycles, MemReady,
        output AluEn, MulEn, ExeMemBufferWr, SetStallDec, ClrStallDec,
               IsExeBusy, CycleCnt, OverrunErr
    );

endinterface

// File: rtl/control_execute.sv
// Execute-stage control FSM: sequences single/multi-cycle ALU ops into the Exe/Mem buffer.
//   state | meaning
//   EXE0  | idle, waiting for a Dec/Exe buffer write
//   EXE1  | result cycle, ALU output valid
//   EXE2  | multi-cycle iteration, counting down
//   EXE3  | result held while memory stage is not ready
module control_execute
    import control_execute_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic CLK,
    input  logic RST,
    control_execute_if.slave bus
);

    exeState_t    state, nextState;
    logic [CNT_W-1:0] cycleCnt, nextCnt;
    logic         stallIssued;
    logic         overrunErr;
    logic         aluEn, mulEn, memWr, setStall, overrun, accept;
    stallStrobe_t stallStb;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= EXE0;
            cycleCnt    <= '0;
            stallIssued <= 1'b0;
            overrunErr  <= 1'b0;
        end else begin
            state       <= nextState;
            cycleCnt    <= nextCnt;
            stallIssued <= stallStb.setStallDec | (stallIssued & ~stallStb.clrStallDec);
            if (overrun) overrunErr <= 1'b1;
        end
    end

    always_comb begin
        nextState = state;
        nextCnt   = cycleCnt;
        aluEn     = 1'b0;
        mulEn     = 1'b0;
        memWr     = 1'b0;
        setStall  = 1'b0;
        overrun   = 1'b0;
        accept    = 1'b0;
        case (state)
            EXE0: begin
                accept = bus.DecExeBufferWr;
            end
            EXE2: begin
                mulEn    = 1'b1;
                setStall = 1'b1;
                overrun  = bus.DecExeBufferWr;
                if (cycleCnt != '0) nextCnt = cycleCnt - CNT_W'(1);
                else                nextState = EXE1;
            end
            EXE1: begin
                aluEn = 1'b1;
                if (bus.MemReady) begin
                    memWr     = 1'b1;
                    accept    = bus.DecExeBufferWr;
                    nextState = EXE0;
                end else begin
                    setStall  = 1'b1;
                    overrun   = bus.DecExeBufferWr;
                    nextState = EXE3;
                end
            end
            EXE3: begin
                if (bus.MemReady) begin
                    memWr     = 1'b1;
                    accept    = bus.DecExeBufferWr;
                    nextState = EXE0;
                end else begin
                    setStall  = 1'b1;
                    overrun   = bus.DecExeBufferWr;
                end
            end
            default: nextState = EXE0;
        endcase

        // New instruction: OpCycles of 0 or 1 collapses to a single-cycle op.
        if (accept) begin
            if (bus.IsMultiCycle && (bus.OpCycles >= CNT_W'(2))) begin
                nextState = EXE2;
                nextCnt   = bus.OpCycles - CNT_W'(2);
                if (state == EXE0) setStall = 1'b1;
            end else begin
                nextState = EXE1;
            end
        end
    end

    assign stallStb = {setStall, stallIssued & memWr};

    assign bus.AluEn          = aluEn;
    assign bus.MulEn          = mulEn;
    assign bus.ExeMemBufferWr = memWr;
    assign bus.SetStallDec    = stallStb.setStallDec;
    assign bus.ClrStallDec    = stallStb.clrStallDec;
    assign bus.IsExeBusy      = (state != EXE0);
    assign bus.CycleCnt       = cycleCnt;
    assign bus.OverrunErr     = overrunErr;

endmodule

// File: tb/tb_control_execute.sv
// Directed bench for control_execute: per-cycle output checks plus a write scoreboard.
module tb_control_execute;

    logic CLK;
    logic RST;

    control_execute_if #(.CNT_W(4)) bus ();

    control_execute #(.CNT_W(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int   cyc;
        logic clr;
    } sbEntry_t;

    sbEntry_t sbQ[$];
    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {AluEn, MulEn, ExeMemBufferWr, SetStallDec, ClrStallDec, IsExeBusy, OverrunErr}
    function automatic logic [6:0] outV();
        return {bus.AluEn, bus.MulEn, bus.ExeMemBufferWr, bus.SetStallDec,
                bus.ClrStallDec, bus.IsExeBusy, bus.OverrunErr};
    endfunction

    task automatic expectWrite(input int lat, input logic clr);
        sbEntry_t e;
        e.cyc = cyc + lat;
        e.clr = clr;
        sbQ.push_back(e);
    endtask

    task automatic monitor();
        sbEntry_t e;
        if (bus.ExeMemBufferWr === 1'b1) begin
            if (sbQ.size() == 0) begin
                chk("sb_unexpected_wr", 32'(sbQ.size()), 32'd1);
            end else begin
                e = sbQ.pop_front();
                chk("sb_wr_cycle", 32'(cyc), 32'(e.cyc));
                chk("sb_wr_clr", {31'd0, bus.ClrStallDec}, {31'd0, e.clr});
            end
        end
    endtask

    // Called just after a falling edge; drives, samples, then advances one cycle.
    task automatic step(input string tag, input logic wr, input logic multi,
                        input logic [3:0] ops, input logic mr,
                        input logic [6:0] expV, input logic [3:0] expCnt);
        bus.DecExeBufferWr = wr;
        bus.IsMultiCycle   = multi;
        bus.OpCycles       = ops;
        bus.MemReady       = mr;
        #1;
        chk({tag, "_out"}, {25'd0, outV()}, {25'd0, expV});
        chk({tag, "_cnt"}, {28'd0, bus.CycleCnt}, {28'd0, expCnt});
        monitor();
        @(negedge CLK);
        cyc++;
    endtask

    initial begin
        RST                = 1'b0;
        bus.DecExeBufferWr = 1'b0;
        bus.IsMultiCycle   = 1'b0;
        bus.OpCycles       = 4'd0;
        bus.MemReady       = 1'b0;
        @(negedge CLK);
        #1;
        chk("rst_out", {25'd0, outV()}, 32'd0);
        chk("rst_cnt", {28'd0, bus.CycleCnt}, 32'd0);
        RST = 1'b1;
        @(negedge CLK);

        // single-cycle op, memory ready
        expectWrite(1, 1'b0);
        step("s1_t0",   1'b1, 1'b0, 4'd0, 1'b1, 7'b0000000, 4'd0);
        step("s1_t1",   1'b0, 1'b0, 4'd0, 1'b1, 7'b1010010, 4'd0);
        step("s1_idle", 1'b0, 1'b0, 4'd0, 1'b1, 7'b0000000, 4'd0);

        // four-cycle op
        expectWrite(4, 1'b1);
        step("m4_t0",   1'b1, 1'b1, 4'd4, 1'b1, 7'b0001000, 4'd0);
        step("m4_t1",   1'b0, 1'b0, 4'd0, 1'b1, 7'b0101010, 4'd2);
        step("m4_t2",   1'b0, 1'b0, 4'd0, 1'b1, 7'b0101010, 4'd1);
        step("m4_t3",   1'b0, 1'b0, 4'd0, 1'b1, 7'b0101010, 4'd0);
        step("m4_t4",   1'b0, 1'b0, 4'd0, 1'b1, 7'b1010110, 4'd0);
        step("m4_idle", 1'b0, 1'b0, 4'd0, 1'b1, 7'b0000000, 4'd0);

        // single-cycle op blocked by memory for three cycles
        expectWrite(4, 1'b1);
        step("h_t0",   1'b1, 1'b0, 4'd0, 1'b0, 7'b0000000, 4'd0);
        step("h_t1",   1'b0, 1'b0, 4'd0, 1'b0, 7'b1001010, 4'd0);
        step("h_t2",   1'b0, 1'b0, 4'd0, 1'b0, 7'b0001010, 4'd0);
        step("h_t3",   1'b0, 1'b0, 4'd0, 1'b0, 7'b0001010, 4'd0);
        step("h_t4",   1'b0, 1'b0, 4'd0, 1'b1, 7'b0010110, 4'd0);
        step("h_idle", 1'b0, 1'b0, 4'd0, 1'b1, 7'b0000000, 4'd0);

        // offer during EXE2 is dropped and flagged; in-flight op unaffected
        expectWrite(3, 1'b1);
        step("o_t0",   1'b1, 1'b1, 4'd3, 1'b1, 7'b0001000, 4'd0);
        step("o_t1",   1'b1, 1'b0, 4'd0, 1'b1, 7'b0101010, 4'd1);
        step("o_t2",   1'b0, 1'b0, 4'd0, 1'b1, 7'b0101011, 4'd0);
        step("o_t3",   1'b0, 1'b0, 4'd0, 1'b1, 7'b1010111, 4'd0);
        step("o_idle", 1'b0, 1'b0, 4'd0, 1'b1, 7'b0000001, 4'd0);

        // back-to-back: single op followed in its result cycle by a two-cycle op
        expectWrite(1, 1'b0);
        step("b_t0",   1'b1, 1'b0, 4'd0, 1'b1, 7'b0000001, 4'd0);
        expectWrite(2, 1'b1);
        step("b_t1",   1'b1, 1'b1, 4'd2, 1'b1, 7'b1010011, 4'd0);
        step("b_t2",   1'b0, 1'b0, 4'd0, 1'b1, 7'b0101011, 4'd0);
        step("b_t3",   1'b0, 1'b0, 4'd0, 1'b1, 7'b1010111, 4'd0);
        step("b_idle", 1'b0, 1'b0, 4'd0, 1'b1, 7'b0000001, 4'd0);

        // reset in the middle of a five-cycle op; no write may follow
        step("r_t0", 1'b1, 1'b1, 4'd5, 1'b1, 7'b0001001, 4'd0);
        step("r_t1", 1'b0, 1'b0, 4'd0, 1'b1, 7'b0101011, 4'd3);
        RST = 1'b0;
        #1;
        chk("r_async_out", {25'd0, outV()}, 32'd0);
        chk("r_async_cnt", {28'd0, bus.CycleCnt}, 32'd0);
        @(negedge CLK);
        cyc++;
        RST = 1'b1;
        step("r_rel0", 1'b0, 1'b0, 4'd0, 1'b1, 7'b0000000, 4'd0);
        step("r_rel1", 1'b0, 1'b0, 4'd0, 1'b1, 7'b0000000, 4'd0);

        chk("sb_drain", 32'(sbQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
